// File: rtl/regfile_sb.sv
// -----------------------------------------------------------------------------
// Module   : regfile_sb
// Purpose  : 2R/1W register file with a per-register pending-write scoreboard.
//            Optional same-cycle write-to-read bypass: define REGFILE_BYPASS_EN.
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr1,
  output logic [DATA_W-1:0] rd_data1,
  output logic              rd_busy1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data2,
  output logic              rd_busy2,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              flush,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int c_DEPTH = 2 ** ADDR_W;
  localparam bit c_ZERO  = (ZERO_REG != 0);

  logic [DATA_W-1:0]  r_regs [c_DEPTH];
  logic [c_DEPTH-1:0] r_busy;
  logic [ADDR_W:0]    r_busy_cnt;

  logic               w_wr_ok;
  logic               w_iss_ok;
  logic               w_cnt_inc;
  logic               w_cnt_dec;
  logic [c_DEPTH-1:0] w_busy_nxt;

  // Register 0 suppression is folded into the strobes so nothing downstream sees it.
  assign w_wr_ok  = wr_en  && !(c_ZERO && (wr_addr  == '0));
  assign w_iss_ok = iss_en && !(c_ZERO && (iss_addr == '0));

  // Issue wins over a same-address writeback: the newer producer is still in flight.
  assign w_cnt_inc = w_iss_ok && !r_busy[iss_addr];
  assign w_cnt_dec = w_wr_ok && r_busy[wr_addr] && !(w_iss_ok && (iss_addr == wr_addr));

  always_comb begin
    w_busy_nxt = r_busy;
    if (w_wr_ok)  w_busy_nxt[wr_addr]  = 1'b0;
    if (w_iss_ok) w_busy_nxt[iss_addr] = 1'b1;
    if (flush)    w_busy_nxt           = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_DEPTH; i++) r_regs[i] <= '0;
    end else if (w_wr_ok) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush) r_busy_cnt <= '0;
      else       r_busy_cnt <= r_busy_cnt + (ADDR_W+1)'(w_cnt_inc) - (ADDR_W+1)'(w_cnt_dec);
    end
  end

  assign busy_cnt = r_busy_cnt;

  always_comb begin
    rd_data1 = r_regs[rd_addr1];
    rd_busy1 = r_busy[rd_addr1];
    rd_data2 = r_regs[rd_addr2];
    rd_busy2 = r_busy[rd_addr2];
`ifdef REGFILE_BYPASS_EN
    if (w_wr_ok && (rd_addr1 == wr_addr)) begin
      rd_data1 = wr_data;
      rd_busy1 = 1'b0;
    end
    if (w_wr_ok && (rd_addr2 == wr_addr)) begin
      rd_data2 = wr_data;
      rd_busy2 = 1'b0;
    end
`endif
    if (c_ZERO && (rd_addr1 == '0)) begin
      rd_data1 = '0;
      rd_busy1 = 1'b0;
    end
    if (c_ZERO && (rd_addr2 == '0)) begin
      rd_data2 = '0;
      rd_busy2 = 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// -----------------------------------------------------------------------------
// Module   : tb_regfile_sb
// Purpose  : Directed self-checking bench for regfile_sb (default parameters).
// Revision : 1.0 - initial release
// -----------------------------------------------------------------------------
`default_nettype none

module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] rd_addr1, rd_addr2, wr_addr, iss_addr;
  logic [DATA_W-1:0] rd_data1, rd_data2, wr_data;
  logic              rd_busy1, rd_busy2, wr_en, iss_en, flush;
  logic [ADDR_W:0]   busy_cnt;

  int n_pass  = 0;
  int n_total = 0;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst),
    .rd_addr1(rd_addr1), .rd_data1(rd_data1), .rd_busy1(rd_busy1),
    .rd_addr2(rd_addr2), .rd_data2(rd_data2), .rd_busy2(rd_busy2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .busy_cnt(busy_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0; rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    wr_addr = '0; wr_data = '0; iss_addr = '0; rd_addr1 = '0; rd_addr2 = '0;
    tick(); tick();
    idle();
    rd_addr1 = 5'd5; rd_addr2 = 5'd0; #1;
    check("reset_cnt",   32'(busy_cnt), 32'd0);
    check("reset_r5",    rd_data1,      32'd0);
    check("reset_busy5", 32'(rd_busy1), 32'd0);

    // Write r5, visible the next cycle on both ports
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr2 = 5'd5;
    tick(); idle(); #1;
    check("r5_port1", rd_data1, 32'hDEADBEEF);
    check("r5_port2", rd_data2, 32'hDEADBEEF);
    check("r5_busy1", 32'(rd_busy1), 32'd0);
    check("r5_busy2", 32'(rd_busy2), 32'd0);
    rd_addr2 = 5'd0; #1;
    check("r0_read", rd_data2, 32'd0);

    // Register 0 ignores writes and issues
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    tick(); idle();
    iss_en = 1'b1; iss_addr = 5'd0;
    tick(); idle(); rd_addr1 = 5'd0; #1;
    check("r0_after_wr", rd_data1, 32'd0);
    check("r0_iss_cnt",  32'(busy_cnt), 32'd0);
    check("r0_iss_busy", 32'(rd_busy1), 32'd0);

    // Issue r3, r7, r3
    iss_en = 1'b1; iss_addr = 5'd3; tick(); #1;
    check("iss_r3_cnt", 32'(busy_cnt), 32'd1);
    iss_addr = 5'd7; tick(); #1;
    check("iss_r7_cnt", 32'(busy_cnt), 32'd2);
    iss_addr = 5'd3; tick(); idle(); #1;
    check("reiss_r3_cnt", 32'(busy_cnt), 32'd2);
    rd_addr1 = 5'd3; rd_addr2 = 5'd7; #1;
    check("r3_busy", 32'(rd_busy1), 32'd1);
    check("r7_busy", 32'(rd_busy2), 32'd1);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    tick(); idle(); #1;
    check("wb_r3_busy", 32'(rd_busy1), 32'd0);
    check("wb_r3_cnt",  32'(busy_cnt), 32'd1);
    check("wb_r3_data", rd_data1, 32'h33);

    // Same-cycle issue and writeback to r9: issue wins
    iss_en = 1'b1; iss_addr = 5'd9; wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hA5A5A5A5;
    tick(); idle(); rd_addr1 = 5'd9; #1;
    check("r9_data", rd_data1, 32'hA5A5A5A5);
    check("r9_busy", 32'(rd_busy1), 32'd1);
    check("r9_cnt",  32'(busy_cnt), 32'd2);

    // Writeback to a non-busy register leaves the count alone
    wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'h88;
    tick(); idle(); rd_addr1 = 5'd8; #1;
    check("wb_idle_cnt",  32'(busy_cnt), 32'd2);
    check("wb_idle_busy", 32'(rd_busy1), 32'd0);

    // Reach 4 busy (r7, r9, r10, r11), then flush with iss r2 and wr r4
    iss_en = 1'b1; iss_addr = 5'd10; tick();
    iss_addr = 5'd11; tick(); idle(); #1;
    check("four_busy_cnt", 32'(busy_cnt), 32'd4);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd2;
    wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    tick(); idle(); rd_addr1 = 5'd2; rd_addr2 = 5'd4; #1;
    check("flush_cnt",   32'(busy_cnt), 32'd0);
    check("flush_r2",    32'(rd_busy1), 32'd0);
    check("flush_r4",    rd_data2, 32'h55);
    rd_addr1 = 5'd7; #1;
    check("flush_r7",    32'(rd_busy1), 32'd0);

    // Bypass behaviour on r6, with a same-cycle issue to r6
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h1111;
    tick(); idle();
    rd_addr1 = 5'd6;
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFE; iss_en = 1'b1; iss_addr = 5'd6; #1;
`ifdef REGFILE_BYPASS_EN
    check("byp_same_data", rd_data1, 32'hCAFE);
`else
    check("byp_same_data", rd_data1, 32'h1111);
`endif
    check("byp_same_busy", 32'(rd_busy1), 32'd0);
    tick(); idle(); #1;
    check("byp_next_data", rd_data1, 32'hCAFE);
    check("byp_next_busy", 32'(rd_busy1), 32'd1);
    check("byp_next_cnt",  32'(busy_cnt), 32'd1);

    // Issue r12 while r6 writes back
    iss_en = 1'b1; iss_addr = 5'd12; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'h66;
    tick(); idle(); rd_addr2 = 5'd12; #1;
    check("mix_cnt",     32'(busy_cnt), 32'd1);
    check("mix_r6_busy", 32'(rd_busy1), 32'd0);
    check("mix_r12_busy", 32'(rd_busy2), 32'd1);

    // Reset beats a same-cycle issue and write
    rst = 1'b1; iss_en = 1'b1; iss_addr = 5'd13; wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h77;
    tick(); idle(); rd_addr1 = 5'd5; rd_addr2 = 5'd13; #1;
    check("rst2_cnt",  32'(busy_cnt), 32'd0);
    check("rst2_r5",   rd_data1, 32'd0);
    check("rst2_busy", 32'(rd_busy2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
